tribus_rx: RTL and testbench

Receive-side endpoint for a shared tri-state bus whose drivers are `bufz` tri-state buffer cells, one per source, each gated by its own enable. On each transfer strobe the block checks the driver enables and classifies the cycle as a clean transfer, a floating bus, or bus contention. Clean words, tagged with the driving source index, are queued in a small FIFO behind a valid/ready handshake. The block also provides a bus-keeper value and sticky error flags for the bus controller.

---
 rtl/tribus_rx.sv | 195 +++++++++++++++++++
 tb/tb_tribus_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tribus_rx.sv
// tribus_rx: receive-side endpoint for a shared tri-state bus.
//
// Each strobed cycle is classified from the driver enable copies:
// exactly one enable is a clean transfer, no enable leaves the bus
// floating, and more than one is contention. Clean words, tagged with
// the index of the driving source, go into a first-word fall-through
// FIFO behind a valid/ready handshake. The block also keeps the last
// clean word (bus keeper) and sticky error flags.
//
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   BUS[WIDTH]           resolved bus value (already synchronous to CLK)
//   DRV_EN[NDRV]         driver enable copies, bit k = driver k driving
//   STB                  transfer strobe
//   Q, QSRC, QVALID      FIFO head data, head source index, head valid
//   QREADY               consumer accepts the head
//   LEVEL[LW]            FIFO occupancy, 0..DEPTH
//   KEEP[WIDTH]          last cleanly received word
//   ERR_FLOAT/CONT/OVF   sticky error flags
//   ERR_CLR              clears all sticky flags
module tribus_rx #(
    parameter int WIDTH = 8,
    parameter int NDRV  = 4,
    parameter int DEPTH = 4,
    localparam int SW   = $clog2(NDRV),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] BUS,
    input  logic [NDRV-1:0]  DRV_EN,
    input  logic             STB,
    output logic [WIDTH-1:0] Q,
    output logic [SW-1:0]    QSRC,
    output logic             QVALID,
    input  logic             QREADY,
    output logic [LW-1:0]    LEVEL,
    output logic [WIDTH-1:0] KEEP,
    output logic             ERR_FLOAT,
    output logic             ERR_CONT,
    output logic             ERR_OVF,
    input  logic             ERR_CLR
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Number of active drivers; SW+1 bits always hold values up to NDRV.
    function automatic logic [SW:0] drv_count(input logic [NDRV-1:0] en);
        logic [SW:0] cnt;
        cnt = {(SW+1){1'b0}};
        for (int k = 0; k < NDRV; k++) begin
            cnt = cnt + {{SW{1'b0}}, en[k]};
        end
        return cnt;
    endfunction

    // Index of a set enable bit; only meaningful when exactly one bit is set.
    function automatic logic [SW-1:0] drv_index(input logic [NDRV-1:0] en);
        logic [SW-1:0] idx;
        idx = {SW{1'b0}};
        for (int k = 0; k < NDRV; k++) begin
            if (en[k]) begin
                idx = SW'(k);
            end
        end
        return idx;
    endfunction

    logic [WIDTH-1:0] data_mem_r [DEPTH];
    logic [SW-1:0]    src_mem_r  [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             qvalid_r;
    logic [WIDTH-1:0] keep_r;
    logic             err_float_r;
    logic             err_cont_r;
    logic             err_ovf_r;

    logic [SW:0]      cnt_s;
    logic [SW-1:0]    idx_s;
    logic             clean_s;
    logic             float_s;
    logic             cont_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             ovf_s;
    logic [LW-1:0]    level_nxt_s;

    // Classify the current strobe from the enable popcount.
    always_comb begin
        cnt_s   = drv_count(DRV_EN);
        idx_s   = drv_index(DRV_EN);
        clean_s = 1'b0;
        float_s = 1'b0;
        cont_s  = 1'b0;
        if (STB) begin
            if (cnt_s == {{SW{1'b0}}, 1'b1}) begin
                clean_s = 1'b1;
            end else if (cnt_s == {(SW+1){1'b0}}) begin
                float_s = 1'b1;
            end else begin
                cont_s = 1'b1;
            end
        end else begin
            clean_s = 1'b0;
            float_s = 1'b0;
            cont_s  = 1'b0;
        end
    end

    // Full: same slot, different lap. A pop in the same cycle frees the
    // slot for the push, so a full FIFO with a pop never overflows.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                     (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign pop_s   = !empty_s && QREADY;
    assign push_s  = clean_s && (!full_s || pop_s);
    assign ovf_s   = clean_s && full_s && !pop_s;

    // Next occupancy from the push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_nxt_s = level_r - {{(LW-1){1'b0}}, 1'b1};
            default: level_nxt_s = level_r;
        endcase
    end

    // FIFO pointers, occupancy and head-valid registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
            qvalid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            level_r  <= level_nxt_s;
            qvalid_r <= (level_nxt_s != {LW{1'b0}});
        end
    end

    // FIFO storage; cleared on reset so the head reads back as zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= {WIDTH{1'b0}};
                src_mem_r[i]  <= {SW{1'b0}};
            end
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r[AW-1:0]] <= BUS;
                src_mem_r[wr_ptr_r[AW-1:0]]  <= idx_s;
            end
        end
    end

    // Bus keeper and sticky flags; a new error wins over a same-cycle clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            keep_r      <= {WIDTH{1'b0}};
            err_float_r <= 1'b0;
            err_cont_r  <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            if (clean_s) begin
                keep_r <= BUS;
            end
            err_float_r <= float_s | (err_float_r & ~ERR_CLR);
            err_cont_r  <= cont_s  | (err_cont_r  & ~ERR_CLR);
            err_ovf_r   <= ovf_s   | (err_ovf_r   & ~ERR_CLR);
        end
    end

    // Head is read straight from storage, so it is stable while stalled.
    assign Q         = data_mem_r[rd_ptr_r[AW-1:0]];
    assign QSRC      = src_mem_r[rd_ptr_r[AW-1:0]];
    assign QVALID    = qvalid_r;
    assign LEVEL     = level_r;
    assign KEEP      = keep_r;
    assign ERR_FLOAT = err_float_r;
    assign ERR_CONT  = err_cont_r;
    assign ERR_OVF   = err_ovf_r;

endmodule

// File: tb/tb_tribus_rx.sv
// Self-checking bench for tribus_rx (WIDTH=8, NDRV=4, DEPTH=4).
// Directed scenarios use constant expectations; the random scenario
// compares against a queue-based reference model.
module tb_tribus_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] BUS = 8'h00;
    logic [3:0] DRV_EN = 4'h0;
    logic       STB = 1'b0;
    logic [7:0] Q;
    logic [1:0] QSRC;
    logic       QVALID;
    logic       QREADY = 1'b0;
    logic [2:0] LEVEL;
    logic [7:0] KEEP;
    logic       ERR_FLOAT;
    logic       ERR_CONT;
    logic       ERR_OVF;
    logic       ERR_CLR = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [9:0] mq[$];
    logic [7:0] m_keep  = 8'h00;
    logic       m_float = 1'b0;
    logic       m_cont  = 1'b0;
    logic       m_ovf   = 1'b0;

    tribus_rx #(.WIDTH(8), .NDRV(4), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .BUS(BUS), .DRV_EN(DRV_EN), .STB(STB),
        .Q(Q), .QSRC(QSRC), .QVALID(QVALID), .QREADY(QREADY),
        .LEVEL(LEVEL), .KEEP(KEEP), .ERR_FLOAT(ERR_FLOAT),
        .ERR_CONT(ERR_CONT), .ERR_OVF(ERR_OVF), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        mq.delete();
        m_keep  = 8'h00;
        m_float = 1'b0;
        m_cont  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle, clock it, advance the model, sample 1 time unit later.
    task automatic cycle(input logic stb, input logic [3:0] en,
                         input logic [7:0] bus, input logic rdy,
                         input logic clr);
        int pc;
        logic [1:0] src;
        logic pop, full, f, c, o;
        STB = stb; DRV_EN = en; BUS = bus; QREADY = rdy; ERR_CLR = clr;
        @(posedge CLK);
        pc   = $countones(en);
        src  = 2'd0;
        for (int k = 0; k < 4; k++) if (en[k]) src = 2'(k);
        full = (mq.size() == 4);
        pop  = (mq.size() != 0) && rdy;
        f = clr ? 1'b0 : m_float;
        c = clr ? 1'b0 : m_cont;
        o = clr ? 1'b0 : m_ovf;
        if (pop) void'(mq.pop_front());
        if (stb) begin
            if (pc == 0) f = 1'b1;
            else if (pc >= 2) c = 1'b1;
            else begin
                m_keep = bus;
                if (!full || pop) mq.push_back({src, bus});
                else o = 1'b1;
            end
        end
        m_float = f; m_cont = c; m_ovf = o;
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        #1;
        checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0 || KEEP !== 8'h00) begin
            failures++; $display("FAIL reset_init qvalid=%0b level=%0d keep=%h exp 0/0/00", QVALID, LEVEL, KEEP); end
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0001, 8'(8'h10 + i), 1'b0, 1'b0);
        checks++; if (LEVEL !== 3'd3) begin
            failures++; $display("FAIL reset_fill level=%0d exp 3", LEVEL); end
        #2 RST = 1'b1;
        #1;
        model_reset();
        checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0 || Q !== 8'h00 || QSRC !== 2'd0) begin
            failures++; $display("FAIL reset_async_fifo qvalid=%0b level=%0d q=%h qsrc=%0d exp all 0", QVALID, LEVEL, Q, QSRC); end
        checks++; if (KEEP !== 8'h00 || {ERR_FLOAT, ERR_CONT, ERR_OVF} !== 3'b000) begin
            failures++; $display("FAIL reset_async_keep keep=%h flags=%b exp 00/000", KEEP, {ERR_FLOAT, ERR_CONT, ERR_OVF}); end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0 || KEEP !== 8'h00 ||
                          {ERR_FLOAT, ERR_CONT, ERR_OVF} !== 3'b000) begin
                failures++; $display("FAIL idle cyc=%0d qvalid=%0b level=%0d keep=%h flags=%b exp 0/0/00/000",
                                     i, QVALID, LEVEL, KEEP, {ERR_FLOAT, ERR_CONT, ERR_OVF}); end
        end
    endtask

    task automatic test_clean();
        cycle(1'b1, 4'b0100, 8'hA5, 1'b0, 1'b0);
        checks++; if (QVALID !== 1'b1 || Q !== 8'hA5 || QSRC !== 2'd2 || KEEP !== 8'hA5 || LEVEL !== 3'd1) begin
            failures++; $display("FAIL clean_push qvalid=%0b q=%h qsrc=%0d keep=%h level=%0d exp 1/a5/2/a5/1",
                                 QVALID, Q, QSRC, KEEP, LEVEL); end
        cycle(1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
        checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0 || KEEP !== 8'hA5) begin
            failures++; $display("FAIL clean_pop qvalid=%0b level=%0d keep=%h exp 0/0/a5", QVALID, LEVEL, KEEP); end
    endtask

    task automatic test_errors();
        cycle(1'b1, 4'b0000, 8'h77, 1'b0, 1'b0);
        checks++; if (ERR_FLOAT !== 1'b1 || LEVEL !== 3'd0 || QVALID !== 1'b0) begin
            failures++; $display("FAIL float err=%0b level=%0d qvalid=%0b exp 1/0/0", ERR_FLOAT, LEVEL, QVALID); end
        cycle(1'b1, 4'b1001, 8'h3C, 1'b0, 1'b0);
        checks++; if (ERR_CONT !== 1'b1 || LEVEL !== 3'd0 || KEEP !== 8'hA5) begin
            failures++; $display("FAIL contention err=%0b level=%0d keep=%h exp 1/0/a5", ERR_CONT, LEVEL, KEEP); end
        cycle(1'b1, 4'b0000, 8'h12, 1'b0, 1'b1);
        checks++; if (ERR_FLOAT !== 1'b1 || ERR_CONT !== 1'b0) begin
            failures++; $display("FAIL clr_set_wins float=%0b cont=%0b exp 1/0", ERR_FLOAT, ERR_CONT); end
        cycle(1'b0, 4'b0000, 8'h00, 1'b0, 1'b1);
        checks++; if ({ERR_FLOAT, ERR_CONT, ERR_OVF} !== 3'b000 || KEEP !== 8'hA5) begin
            failures++; $display("FAIL clr_all flags=%b keep=%h exp 000/a5", {ERR_FLOAT, ERR_CONT, ERR_OVF}, KEEP); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0010, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        checks++; if (LEVEL !== 3'd4 || Q !== 8'h11) begin
            failures++; $display("FAIL ovf_fill level=%0d q=%h exp 4/11", LEVEL, Q); end
        cycle(1'b1, 4'b0010, 8'h55, 1'b0, 1'b0);
        checks++; if (ERR_OVF !== 1'b1 || KEEP !== 8'h55 || LEVEL !== 3'd4 || Q !== 8'h11) begin
            failures++; $display("FAIL ovf_drop ovf=%0b keep=%h level=%0d q=%h exp 1/55/4/11", ERR_OVF, KEEP, LEVEL, Q); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(8'h11 * (i + 1));
            checks++; if (QVALID !== 1'b1 || Q !== exp_d || QSRC !== 2'd1) begin
                failures++; $display("FAIL ovf_drain idx=%0d qvalid=%0b q=%h qsrc=%0d exp 1/%h/1", i, QVALID, Q, QSRC, exp_d); end
            cycle(1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0) begin
            failures++; $display("FAIL ovf_empty qvalid=%0b level=%0d exp 0/0", QVALID, LEVEL); end
        cycle(1'b0, 4'b0000, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q[4];
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h66;
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0010, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
        cycle(1'b1, 4'b0010, 8'h66, 1'b1, 1'b0);
        checks++; if (ERR_OVF !== 1'b0 || LEVEL !== 3'd4 || Q !== 8'h22 || KEEP !== 8'h66) begin
            failures++; $display("FAIL full_pushpop ovf=%0b level=%0d q=%h keep=%h exp 0/4/22/66", ERR_OVF, LEVEL, Q, KEEP); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (QVALID !== 1'b1 || Q !== exp_q[i]) begin
                failures++; $display("FAIL full_drain idx=%0d qvalid=%0b q=%h exp 1/%h", i, QVALID, Q, exp_q[i]); end
            cycle(1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0) begin
            failures++; $display("FAIL full_empty qvalid=%0b level=%0d exp 0/0", QVALID, LEVEL); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] en;
        logic [7:0] d;
        cycle(1'b0, 4'b0000, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            en = 4'b0001 << (i % 4);
            d  = 8'(8'h40 + i);
            cycle(1'b1, en, d, 1'b1, 1'b0);
            checks++; if (QVALID !== 1'b1 || Q !== d || QSRC !== 2'(i % 4) || LEVEL > 3'd1 ||
                          {ERR_FLOAT, ERR_CONT, ERR_OVF} !== 3'b000) begin
                failures++; $display("FAIL b2b idx=%0d qvalid=%0b q=%h qsrc=%0d level=%0d flags=%b exp 1/%h/%0d/<=1/000",
                                     i, QVALID, Q, QSRC, LEVEL, {ERR_FLOAT, ERR_CONT, ERR_OVF}, d, i % 4); end
        end
        cycle(1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
        checks++; if (QVALID !== 1'b0 || LEVEL !== 3'd0) begin
            failures++; $display("FAIL b2b_empty qvalid=%0b level=%0d exp 0/0", QVALID, LEVEL); end
    endtask

    task automatic test_random();
        logic [3:0] en;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) < 5) en = 4'b0001 << $urandom_range(0, 3);
            else en = 4'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), en, 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            checks++; if (QVALID !== (mq.size() != 0) || LEVEL !== 3'(mq.size())) begin
                failures++; $display("FAIL rand_occ cyc=%0d qvalid=%0b level=%0d exp level %0d", i, QVALID, LEVEL, mq.size()); end
            if (mq.size() != 0) begin
                checks++; if ({QSRC, Q} !== mq[0]) begin
                    failures++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", i, {QSRC, Q}, mq[0]); end
            end
            checks++; if (KEEP !== m_keep || {ERR_FLOAT, ERR_CONT, ERR_OVF} !== {m_float, m_cont, m_ovf}) begin
                failures++; $display("FAIL rand_keepflags cyc=%0d keep=%h flags=%b exp %h/%b", i, KEEP,
                                     {ERR_FLOAT, ERR_CONT, ERR_OVF}, m_keep, {m_float, m_cont, m_ovf}); end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
